alu_control_seq: RTL and testbench
==================================

Name: alu_control_seq

Overview:
- Parametrised successor of the single-cycle ALU control decoder.
- Decodes ALUop/FieldFunc into the ALU control code exactly as the current datapath expects.
- Adds a multi-cycle sequencer for mult/multu/div/divu with HI/LO registers and mfhi/mflo/mthi/mtlo support.
- Provides a Stall output so the non-pipelined control FSM holds the PC while an iterative operation runs.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be an even value, 8 or more.
- CTRL_W, 4, ALU control code width; codes are zero-extended if CTRL_W > 4.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- ALUop  in  2  operation class from main control.
- FieldFunc  in  6  R-type funct field.
- Start  in  1  qualifies FieldFunc for the sequenced ops; single-cycle pulse from main control.
- OpA  in  WIDTH  rs operand (dividend / multiplicand / mthi, mtlo source).
- OpB  in  WIDTH  rt operand (divisor / multiplier).
- ALUConInput  out  CTRL_W  ALU control code, combinational.
- IllegalOp  out  1  combinational; high when ALUop=10 and the funct is not recognised.
- Stall  out  1  high while the sequencer is busy.
- Done  out  1  one-cycle pulse when HI/LO are updated by mult/div.
- DivZero  out  1  one-cycle pulse, coincident with Done, for divide by zero.
- HiOut  out  WIDTH  HI register.
- LoOut  out  WIDTH  LO register.
- HiLoSel  out  2  result mux select: 00 ALU, 01 HI (mfhi), 10 LO (mflo).

Behaviour:
- Decode is combinational and has no latches; every path assigns all outputs.
  - ALUop=00 -> 0010 (add).
  - ALUop=01 -> 0110 (sub).
  - ALUop=10 -> by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111.
  - ALUop=10, funct 010000 (mfhi) -> 0010, HiLoSel=01.
  - ALUop=10, funct 010010 (mflo) -> 0010, HiLoSel=10.
  - ALUop=10, funct 011000/011001/011010/011011/010001/010011 -> 0010, HiLoSel=00.
  - ALUop=10, any other funct -> 1111, IllegalOp=1.
  - ALUop=11 -> 1111, IllegalOp=0.
- Sequencer states: IDLE, MUL, DIV, FIN.
  - IDLE -> MUL: Start=1, ALUop=10, funct 011000 (signed) or 011001 (unsigned). Capture OpA/OpB and signedness.
  - IDLE -> DIV: Start=1, ALUop=10, funct 011010 (signed) or 011011 (unsigned). Capture OpA/OpB and signedness.
  - mthi/mtlo with Start=1 in IDLE: write OpA to HI/LO at that edge; stay in IDLE; no Done pulse.
  - MUL: shift-add, one bit per cycle, WIDTH cycles, then -> FIN.
  - DIV: restoring division, one bit per cycle, WIDTH cycles, then -> FIN.
  - FIN: write HI/LO, pulse Done, -> IDLE.
- Latency: Start sampled at edge k; Stall=1 from edge k through edge k+WIDTH+1. HI/LO update and Done=1 for the single cycle following edge k+WIDTH+1. Stall is low during the Done cycle.
- Results:
  - mult: {HI,LO} = full 2*WIDTH product.
  - div: LO = quotient, HI = remainder.
  - Signed ops compute on magnitudes, then fix signs: quotient negative if operand signs differ; remainder takes the dividend's sign.
- Boundary conditions:
  - Divide by zero: same latency; LO = all ones, HI = OpA; DivZero pulses with Done.
  - Signed most-negative / -1: LO = most-negative, HI = 0; no flag.
  - Start while Stall=1: ignored, including mthi/mtlo.
  - Operands are registered at Start; OpA/OpB changes mid-operation have no effect.
  - Asynchronous reset mid-operation: state -> IDLE; HI, LO, Stall, Done and DivZero all -> 0 immediately; the partial result is discarded.

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined: divider datapath and the DIV state are present, as described above.
- Undefined: no divider logic. Funct 011010/011011 decode as illegal (ALUConInput=1111, IllegalOp=1), Start on them is ignored, and DivZero is tied to 0.

Test Plan:
- Decode sweep: ALUop=10 with funct 100000/100010/100100/100101/101010 -> 0010/0110/0000/0001/0111, IllegalOp=0. Funct 000111 -> 1111, IllegalOp=1.
- multu WIDTH=32: OpA=FFFFFFFF, OpB=00000002 -> Stall for 33 cycles, Done at cycle 34, HI=00000001, LO=FFFFFFFE.
- mult signed: OpA=FFFFFFFD (-3), OpB=00000007 -> HI=FFFFFFFF, LO=FFFFFFEB.
- div signed: OpA=FFFFFFF9 (-7), OpB=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF. divu by 0 with OpA=00000064 -> LO=FFFFFFFF, HI=00000064, DivZero=1.
- mthi with OpA=12345678, then mflo decode -> HiOut=12345678 after one edge, HiLoSel=10. Start asserted during a busy mult is ignored and the result is unchanged.
- rst_n low at iteration 10 of a mult -> Stall, Done, HI and LO all 0 immediately; no Done pulse after release; the next mult completes normally.

Source files
------------

// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - ALU control decode plus multi-cycle mult/div sequencer with HI/LO registers
// Define ALU_DIV_EN to include the restoring divider and the DIV state.
module alu_control_seq #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        ALUop,
    input  logic [5:0]        FieldFunc,
    input  logic              Start,
    input  logic [WIDTH-1:0]  OpA,
    input  logic [WIDTH-1:0]  OpB,
    output logic [CTRL_W-1:0] ALUConInput,
    output logic              IllegalOp,
    output logic              Stall,
    output logic              Done,
    output logic              DivZero,
    output logic [WIDTH-1:0]  HiOut,
    output logic [WIDTH-1:0]  LoOut,
    output logic [1:0]        HiLoSel
);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
`ifdef ALU_DIV_EN
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
`endif
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   addend;
    logic               neg_res;
    logic [3:0]         code;

    always_comb begin
        code      = 4'b1111;
        IllegalOp = 1'b0;
        HiLoSel   = 2'b00;
        case (ALUop)
            2'b00: code = 4'b0010;
            2'b01: code = 4'b0110;
            2'b10: begin
                case (FieldFunc)
                    F_ADD:  code = 4'b0010;
                    F_SUB:  code = 4'b0110;
                    F_AND:  code = 4'b0000;
                    F_OR:   code = 4'b0001;
                    F_SLT:  code = 4'b0111;
                    F_MFHI: begin
                        code    = 4'b0010;
                        HiLoSel = 2'b01;
                    end
                    F_MFLO: begin
                        code    = 4'b0010;
                        HiLoSel = 2'b10;
                    end
                    F_MULT, F_MULTU, F_MTHI, F_MTLO: code = 4'b0010;
`ifdef ALU_DIV_EN
                    F_DIV, F_DIVU: code = 4'b0010;
`endif
                    default: begin
                        code      = 4'b1111;
                        IllegalOp = 1'b1;
                    end
                endcase
            end
            default: code = 4'b1111;
        endcase
    end

    assign ALUConInput = CTRL_W'(code);

    // Sequenced ops are only accepted in IDLE; funct bit 0 clear marks the signed variants.
    logic             go;
    logic             op_signed;
    logic             start_mul;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign go        = Start && (ALUop == 2'b10) && (state == IDLE);
    assign op_signed = ~FieldFunc[0];
    assign start_mul = go && ((FieldFunc == F_MULT) || (FieldFunc == F_MULTU));
    assign mag_a     = (op_signed && OpA[WIDTH-1]) ? -OpA : OpA;
    assign mag_b     = (op_signed && OpB[WIDTH-1]) ? -OpB : OpB;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, addend} : {(WIDTH+1){1'b0}});
    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_res ? -prod : prod;

`ifdef ALU_DIV_EN
    logic             start_div;
    logic             is_div;
    logic             neg_rem;
    logic             dvsr_zero;
    logic [WIDTH-1:0] opa_raw;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign start_div = go && ((FieldFunc == F_DIV) || (FieldFunc == F_DIVU));
    // Partial remainder is always below the divisor, so the borrow bit alone decides the quotient bit.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, addend};
    assign div_ge    = ~div_diff[WIDTH];
    assign q_fix     = neg_res ? -acc_lo : acc_lo;
    assign r_fix     = neg_rem ? -acc_hi : acc_hi;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            addend    <= '0;
            neg_res   <= 1'b0;
            HiOut     <= '0;
            LoOut     <= '0;
            Stall     <= 1'b0;
            Done      <= 1'b0;
            DivZero   <= 1'b0;
`ifdef ALU_DIV_EN
            is_div    <= 1'b0;
            neg_rem   <= 1'b0;
            dvsr_zero <= 1'b0;
            opa_raw   <= '0;
`endif
        end else begin
            Done    <= 1'b0;
            DivZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mul) begin
                        state   <= MUL;
                        Stall   <= 1'b1;
                        cnt     <= CNT_W'(WIDTH - 1);
                        acc_hi  <= '0;
                        acc_lo  <= mag_b;
                        addend  <= mag_a;
                        neg_res <= op_signed && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
`ifdef ALU_DIV_EN
                        is_div  <= 1'b0;
                    end else if (start_div) begin
                        state     <= DIV;
                        Stall     <= 1'b1;
                        cnt       <= CNT_W'(WIDTH - 1);
                        acc_hi    <= '0;
                        acc_lo    <= mag_a;
                        addend    <= mag_b;
                        neg_res   <= op_signed && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
                        neg_rem   <= op_signed && OpA[WIDTH-1];
                        dvsr_zero <= (OpB == '0);
                        opa_raw   <= OpA;
                        is_div    <= 1'b1;
`endif
                    end else if (go && (FieldFunc == F_MTHI)) begin
                        HiOut <= OpA;
                    end else if (go && (FieldFunc == F_MTLO)) begin
                        LoOut <= OpA;
                    end
                end
                MUL: begin
                    {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    if (cnt == '0) state <= FIN;
                    else           cnt   <= cnt - 1'b1;
                end
`ifdef ALU_DIV_EN
                DIV: begin
                    acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    if (cnt == '0) state <= FIN;
                    else           cnt   <= cnt - 1'b1;
                end
`endif
                FIN: begin
                    state <= IDLE;
                    Stall <= 1'b0;
                    Done  <= 1'b1;
`ifdef ALU_DIV_EN
                    if (is_div) begin
                        if (dvsr_zero) begin
                            LoOut   <= '1;
                            HiOut   <= opa_raw;
                            DivZero <= 1'b1;
                        end else begin
                            LoOut <= q_fix;
                            HiOut <= r_fix;
                        end
                    end else begin
                        HiOut <= prod_fix[2*WIDTH-1:WIDTH];
                        LoOut <= prod_fix[WIDTH-1:0];
                    end
`else
                    HiOut <= prod_fix[2*WIDTH-1:WIDTH];
                    LoOut <= prod_fix[WIDTH-1:0];
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - self-checking bench for alu_control_seq against an arithmetic reference model
module tb_alu_control_seq;

    localparam int W = 32;
`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   ALUop = 2'b00;
    logic [5:0]   FieldFunc = 6'd0;
    logic         Start = 1'b0;
    logic [W-1:0] OpA = '0;
    logic [W-1:0] OpB = '0;
    logic [3:0]   ALUConInput;
    logic         IllegalOp;
    logic         Stall;
    logic         Done;
    logic         DivZero;
    logic [W-1:0] HiOut;
    logic [W-1:0] LoOut;
    logic [1:0]   HiLoSel;

    int n_assert = 0;
    int n_fail   = 0;

    alu_control_seq #(.WIDTH(W), .CTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ALUop(ALUop), .FieldFunc(FieldFunc), .Start(Start),
        .OpA(OpA), .OpB(OpB), .ALUConInput(ALUConInput), .IllegalOp(IllegalOp),
        .Stall(Stall), .Done(Done), .DivZero(DivZero), .HiOut(HiOut), .LoOut(LoOut),
        .HiLoSel(HiLoSel)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decode table from the operation class and funct field.
    function automatic logic [6:0] decode_ref(input logic [1:0] op, input logic [5:0] f);
        logic [3:0] c;
        logic       ill;
        logic [1:0] sel;
        c = 4'b1111; ill = 1'b0; sel = 2'b00;
        if (op == 2'b00) c = 4'b0010;
        else if (op == 2'b01) c = 4'b0110;
        else if (op == 2'b10) begin
            if      (f == 6'b100000) c = 4'b0010;
            else if (f == 6'b100010) c = 4'b0110;
            else if (f == 6'b100100) c = 4'b0000;
            else if (f == 6'b100101) c = 4'b0001;
            else if (f == 6'b101010) c = 4'b0111;
            else if (f == F_MFHI) begin c = 4'b0010; sel = 2'b01; end
            else if (f == F_MFLO) begin c = 4'b0010; sel = 2'b10; end
            else if (f == F_MULT || f == F_MULTU || f == F_MTHI || f == F_MTLO) c = 4'b0010;
            else if (DIV_EN && (f == F_DIV || f == F_DIVU)) c = 4'b0010;
            else ill = 1'b1;
        end
        return {c, ill, sel};
    endfunction

    function automatic logic [63:0] mul_ref(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        if (sgn) begin sa = $signed(a); sb = $signed(b); end
        else begin sa = {32'b0, a}; sb = {32'b0, b}; end
        return 64'(sa * sb);
    endfunction

    function automatic logic [63:0] div_ref(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        if (b == '0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin sa = $signed(a); sb = $signed(b); end
        else begin sa = {32'b0, a}; sb = {32'b0, b}; end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Launches one sequenced op, scrambles operands while busy, optionally injects a Start mid-run.
    task automatic run_op(input string tag, input logic [5:0] fn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [63:0] exp_hilo, input bit exp_dz,
                          input int inject_at, input logic [5:0] inject_fn);
        int done_at, stall_cnt;
        logic stall_at_done, dz_at_done;
        logic [W-1:0] hi_at_done, lo_at_done;
        done_at = 0; stall_cnt = 0;
        stall_at_done = 1'b1; dz_at_done = 1'b0; hi_at_done = '0; lo_at_done = '0;
        @(negedge clk);
        ALUop = 2'b10; FieldFunc = fn; OpA = a; OpB = b; Start = 1'b1;
        for (int i = 1; i <= 100 && done_at == 0; i++) begin
            @(negedge clk);
            Start = 1'b0; FieldFunc = fn;
            if (Done) begin
                done_at = i; stall_at_done = Stall; dz_at_done = DivZero;
                hi_at_done = HiOut; lo_at_done = LoOut;
            end else if (Stall) stall_cnt++;
            OpA = $urandom; OpB = $urandom;
            if (i == inject_at) begin Start = 1'b1; FieldFunc = inject_fn; end
        end
        chk({tag, " done cycle"}, done_at, W + 2);
        chk({tag, " stall cycles"}, stall_cnt, W + 1);
        chk({tag, " stall low at done"}, stall_at_done, 1'b0);
        chk({tag, " hi"}, hi_at_done, exp_hilo[63:32]);
        chk({tag, " lo"}, lo_at_done, exp_hilo[31:0]);
        chk({tag, " divzero"}, dz_at_done, exp_dz);
        @(negedge clk);
        chk({tag, " done pulse ends"}, {Done, DivZero}, 2'b00);
    endtask

    logic [6:0]   dref;
    logic [W-1:0] ra, rb, val;
    logic [5:0]   rfn;
    int           cnt_done, cnt_stall;

    initial begin
        #1;
        chk("reset outputs", {HiOut, LoOut, Stall, Done, DivZero}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int op = 0; op < 4; op++) begin
            for (int f = 0; f < 64; f++) begin
                ALUop = 2'(op); FieldFunc = 6'(f);
                #1;
                dref = decode_ref(2'(op), 6'(f));
                chk($sformatf("decode op=%0d f=%02h", op, f), {ALUConInput, IllegalOp, HiLoSel}, dref);
            end
        end

        run_op("multu ffffffff*2", F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002,
               64'h0000_0001_FFFF_FFFE, 1'b0, 0, 6'd0);
        run_op("mult -3*7", F_MULT, 32'hFFFF_FFFD, 32'h0000_0007,
               64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 0, 6'd0);

        for (int k = 0; k < 8; k++) begin
            ra = $urandom; rb = $urandom;
            if (k == 0) begin ra = 32'h8000_0000; rb = 32'h8000_0000; end
            if (k == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (k == 2) rb = '0;
            rfn = (k % 2 == 0) ? F_MULT : F_MULTU;
            run_op($sformatf("rand mul %0d", k), rfn, ra, rb, mul_ref(rfn == F_MULT, ra, rb), 1'b0, 0, 6'd0);
        end

        run_op("busy mthi ignored", F_MULTU, 32'h0001_0003, 32'h0000_0005,
               mul_ref(1'b0, 32'h0001_0003, 32'h0000_0005), 1'b0, 5, F_MTHI);
        run_op("busy mult ignored", F_MULT, 32'hFFFF_FF00, 32'h0000_1234,
               mul_ref(1'b1, 32'hFFFF_FF00, 32'h0000_1234), 1'b0, 9, F_MULTU);

        @(negedge clk);
        ALUop = 2'b10; FieldFunc = F_MTHI; OpA = 32'h1234_5678; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; FieldFunc = F_MFLO;
        #1;
        chk("mthi hi", HiOut, 32'h1234_5678);
        chk("mthi no stall/done", {Stall, Done}, 2'b00);
        chk("mflo decode", {ALUConInput, HiLoSel}, {4'b0010, 2'b10});
        val = $urandom;
        @(negedge clk);
        FieldFunc = F_MTLO; OpA = val; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        chk("mtlo lo", LoOut, val);
        chk("mtlo hi kept", HiOut, 32'h1234_5678);

        @(negedge clk);
        if (DIV_EN) begin
            run_op("div -7/2", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002,
                   64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 0, 6'd0);
            run_op("divu 100/0", F_DIVU, 32'h0000_0064, 32'h0000_0000,
                   64'h0000_0064_FFFF_FFFF, 1'b1, 0, 6'd0);
            run_op("div min/-1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                   64'h0000_0000_8000_0000, 1'b0, 0, 6'd0);
            run_op("div neg/0", F_DIV, 32'hFFFF_FF85, 32'h0000_0000,
                   64'hFFFF_FF85_FFFF_FFFF, 1'b1, 0, 6'd0);
            for (int k = 0; k < 6; k++) begin
                ra = $urandom; rb = (k == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
                rfn = (k % 2 == 0) ? F_DIV : F_DIVU;
                run_op($sformatf("rand div %0d", k), rfn, ra, rb, div_ref(rfn == F_DIV, ra, rb),
                       rb == '0, 0, 6'd0);
            end
        end else begin
            ALUop = 2'b10; FieldFunc = F_DIVU; OpA = 32'h64; OpB = 32'h3; Start = 1'b1;
            #1;
            chk("div disabled decode", {ALUConInput, IllegalOp}, {4'b1111, 1'b1});
            @(negedge clk);
            Start = 1'b0;
            repeat (3) @(negedge clk);
            chk("div disabled no start", {Stall, Done, DivZero}, 3'b000);
        end

        run_op("pre-reset mult", F_MULTU, 32'h0000_00FF, 32'h0000_0101,
               mul_ref(1'b0, 32'h0000_00FF, 32'h0000_0101), 1'b0, 0, 6'd0);
        ALUop = 2'b10; FieldFunc = F_MULT; OpA = 32'h7654_3210; OpB = 32'h0000_0033; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre-reset busy", Stall, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset clears", {HiOut, LoOut, Stall, Done, DivZero}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_done = 0; cnt_stall = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (Done) cnt_done++;
            if (Stall) cnt_stall++;
        end
        chk("no done after reset", cnt_done, 0);
        chk("no stall after reset", cnt_stall, 0);
        run_op("post-reset mult", F_MULT, 32'h8765_4321, 32'hFEDC_BA98,
               mul_ref(1'b1, 32'h8765_4321, 32'hFEDC_BA98), 1'b0, 0, 6'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
